// File: rtl/riscv_crypto_saes32_col_seq.sv
`default_nettype none
// ============================================================================
// riscv_crypto_saes32_col_seq
// Builds one AES round column by stepping a shared saes32 FU through bs=0..3.
// Revision: 1.0
// ============================================================================
module riscv_crypto_saes32_col_seq #(
  parameter int FU_LATENCY = 0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_rk,
  input  logic [31:0] in_s0,
  input  logic [31:0] in_s1,
  input  logic [31:0] in_s2,
  input  logic [31:0] in_s3,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rd,
  output logic [31:0] fu_rs1,
  output logic [31:0] fu_rs2,
  output logic [1:0]  fu_bs,
  output logic        fu_op_encs,
  output logic        fu_op_encsm,
  output logic        fu_op_decs,
  output logic        fu_op_decsm,
  input  logic [31:0] fu_rd
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_acc;
  logic [1:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_s [4];
  logic        w_accept;
  logic        w_step;
  logic        w_fu_busy;

  assign w_accept = (r_state == c_ST_IDLE) && in_valid && !flush;
  // The FU result is folded into the accumulator in ISSUE for a
  // combinational FU, or one cycle later in WAIT for a registered one.
  assign w_step   = !flush &&
                    (((r_state == c_ST_ISSUE) && (FU_LATENCY == 0)) ||
                     (r_state == c_ST_WAIT));

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_acc <= 32'h0;
      r_cnt <= 2'd0;
      r_op  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_s[i] <= 32'h0;
      end
    end else if (w_accept) begin
      r_acc  <= in_rk;
      r_cnt  <= 2'd0;
      r_op   <= in_op;
      r_s[0] <= in_s0;
      r_s[1] <= in_s1;
      r_s[2] <= in_s2;
      r_s[3] <= in_s3;
    end else if (w_step) begin
      r_acc <= fu_rd;
      if (r_cnt != 2'd3) begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (in_valid) w_state_nxt = c_ST_ISSUE;
        end
        c_ST_ISSUE: begin
          if (FU_LATENCY != 0)     w_state_nxt = c_ST_WAIT;
          else if (r_cnt == 2'd3)  w_state_nxt = c_ST_DONE;
        end
        c_ST_WAIT: begin
          w_state_nxt = (r_cnt == 2'd3) ? c_ST_DONE : c_ST_ISSUE;
        end
        c_ST_DONE: begin
          if (out_ready) w_state_nxt = c_ST_IDLE;
        end
        default: w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_fu_busy   = (r_state == c_ST_ISSUE) || (r_state == c_ST_WAIT);
    in_ready    = (r_state == c_ST_IDLE);
    out_valid   = (r_state == c_ST_DONE);
    out_rd      = out_valid ? r_acc : 32'h0;
    fu_rs1      = 32'h0;
    fu_rs2      = 32'h0;
    fu_bs       = 2'd0;
    fu_op_encs  = 1'b0;
    fu_op_encsm = 1'b0;
    fu_op_decs  = 1'b0;
    fu_op_decsm = 1'b0;
    if (w_fu_busy) begin
      fu_rs1      = r_acc;
      fu_rs2      = r_s[r_cnt];
      fu_bs       = r_cnt;
      fu_op_encs  = (r_op == 2'd0);
      fu_op_encsm = (r_op == 2'd1);
      fu_op_decs  = (r_op == 2'd2);
      fu_op_decsm = (r_op == 2'd3);
    end
  end

endmodule
`default_nettype wire

// File: doc/riscv_crypto_saes32_col_seq.md
Name: riscv_crypto_saes32_col_seq

Overview:
- Sequencer that computes one full AES round output column by driving a single shared saes32 functional unit four times, with byte select 0..3.
- Accumulates: acc = rk; then for k = 0..3, acc = saes32(rs1=acc, rs2=s_k, bs=k, op).
- Sits between the crypto issue logic and one saes32 FU instance, so a column costs one instruction-level request instead of four.

Parameters:
- FU_LATENCY, 0, cycles from FU inputs to valid fu_rd. Legal values are 0 (combinational, same cycle) and 1 (registered FU).

Ports:
- g_clk  in  1  clock
- g_resetn  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_op  in  2  operation: 0 encs, 1 encsm, 2 decs, 3 decsm
- in_rk  in  32  round key word (initial accumulator)
- in_s0, in_s1, in_s2, in_s3  in  32 each  state words; byte k is taken from in_sk
- flush  in  1  synchronous abort
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_rd  out  32  column result
- fu_rs1  out  32  FU rs1 (accumulator)
- fu_rs2  out  32  FU rs2 (selected state word)
- fu_bs  out  2  FU byte select
- fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm  out  1 each  one-hot FU op strobes
- fu_rd  in  32  FU result

Behaviour:
- Reset (async, g_resetn low):
  - state goes to IDLE; acc, cnt and all latched inputs clear to 0.
  - in_ready=1, out_valid=0, out_rd=0; all fu_* outputs 0.
- States: IDLE, ISSUE, WAIT (used only when FU_LATENCY=1), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch op and s0..s3, set acc<=in_rk, cnt<=0, go to ISSUE.
  - in_valid while in_ready=0 is ignored. The requester holds the request until accepted.
- ISSUE:
  - Drives fu_rs1=acc, fu_rs2=s[cnt], fu_bs=cnt, and exactly one op strobe per the latched op.
  - FU_LATENCY=0: acc<=fu_rd at the end of the cycle. If cnt==3, go to DONE; otherwise cnt<=cnt+1 and stay in ISSUE.
  - FU_LATENCY=1: go to WAIT. FU inputs and strobe stay held stable through WAIT.
- WAIT:
  - acc<=fu_rd.
  - If cnt==3, go to DONE; otherwise cnt<=cnt+1 and go to ISSUE.
- DONE:
  - out_valid=1, out_rd=acc. out_rd is stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
- Outside ISSUE/WAIT, all fu_* outputs are 0 and all op strobes are low.
- in_ready is 1 only in IDLE, so there is no accept in the same cycle as a DONE handshake.
- Latency from accept edge to out_valid rising: 4 cycles (FU_LATENCY=0) or 8 cycles (FU_LATENCY=1).
- Throughput with out_ready held at 1: one result per 6 or 10 cycles respectively.
- cnt is 2 bits and never wraps within a request; it is reset to 0 on every accept.
- flush=1 in any state: next state IDLE, out_valid drops the next cycle, the result is discarded, acc and cnt are unchanged (don't-care).
- flush has priority over in_valid, out_ready and sequencing in the same cycle.
- flush together with an IDLE accept: the request is NOT accepted.
- Reset asserted mid-sequence aborts immediately (asynchronous) with no output produced.

Test Plan:
- FU_LATENCY=0 with the real saes32 attached: op=encs, rk=0, s0..s3=0 -> fu_bs sequence 0,1,2,3 on consecutive cycles; out_valid 4 cycles after accept; out_rd=0x63636363.
- op=decs, rk=0xFFFFFFFF, s=0 -> inverse S-box of 0x00 is 0x52, giving out_rd=0xADADADAD. op=encsm, rk=0, s=0 -> 0x63636363. Both checked against a golden model for 1000 random requests.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_rd held, in_ready=0, fu strobes low. Release out_ready -> IDLE next cycle, and a new request is accepted the cycle after.
- flush asserted when cnt==2 -> IDLE next cycle, no out_valid. Next request (rk=0, s=0, encs) returns 0x63636363.
- FU_LATENCY=1 with a registered FU model -> each fu_bs value is held 2 cycles; out_valid 8 cycles after accept; same result values as the FU_LATENCY=0 checks.
- g_resetn pulsed low during ISSUE -> all outputs 0 immediately and in_ready=1 after release. in_valid held during reset is not accepted until the first edge after release.
